// File: rtl/segasys1_tilerom_arb.sv
// Tile character ROM arbiter for the System 1 video path.
// Gives BG0 and BG1 one guaranteed fetch slot per 8-pixel character period
// and serves an auxiliary reader through a req/ack handshake in the
// remaining cycles. BG data is re-timed so both layers update together on
// the character boundary.
module segasys1_tilerom_arb #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 24
) (
    input  logic          VCLKx8,
    input  logic          RESET_N,
    input  logic          VCLK_EN,
    input  logic [2:0]    HPH,
    input  logic          HOLD,
    input  logic [AW-1:0] BG0_AD,
    input  logic [AW-1:0] BG1_AD,
    output logic [DW-1:0] BG0_DT,
    output logic [DW-1:0] BG1_DT,
    output logic          BG_STB,
    input  logic          AUX_REQ,
    input  logic [AW-1:0] AUX_AD,
    output logic          AUX_ACK,
    output logic [DW-1:0] AUX_DT,
    output logic [AW-1:0] ROM_AD,
    input  logic [DW-1:0] ROM_DT
);

    // Owner of the access issued in the previous cycle; steers ROM_DT capture.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_BG0  = 2'd1,
        TAG_BG1  = 2'd2,
        TAG_AUX  = 2'd3
    } tag_e;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_WAIT = 2'd1,
        A_ACK  = 2'd2
    } aux_state_e;

    aux_state_e    aux_state_q, aux_state_d;
    tag_e          tag_q, tag_d;
    logic [AW-1:0] rom_ad_q, rom_ad_d;
    logic [DW-1:0] bg0_hold_q, bg0_hold_d;
    logic [DW-1:0] bg1_hold_q, bg1_hold_d;
    logic [DW-1:0] bg0_dt_q, bg0_dt_d;
    logic [DW-1:0] bg1_dt_q, bg1_dt_d;
    logic          bg_stb_q, bg_stb_d;
    logic [DW-1:0] aux_dt_q, aux_dt_d;
    logic          aux_ack_q, aux_ack_d;

    logic          bg_slot_cycle;
    logic          slot_bg0;
    logic          slot_bg1;
    logic          aux_issue;
    logic          aux_capture;

    // BG slot decode; a BG slot cycle blocks aux even when HOLD suppresses the slot itself.
    always_comb begin
        bg_slot_cycle = VCLK_EN && ((HPH == 3'd0) || (HPH == 3'd4));
        slot_bg0      = VCLK_EN && (HPH == 3'd0) && !HOLD;
        slot_bg1      = VCLK_EN && (HPH == 3'd4) && !HOLD;
    end

    // Aux FSM state register.
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            aux_state_q <= A_IDLE;
        end else begin
            aux_state_q <= aux_state_d;
        end
    end

    // Aux FSM next state: issue, wait one cycle for data, then one dead cycle.
    always_comb begin
        aux_state_d = aux_state_q;
        unique case (aux_state_q)
            A_IDLE:  if (aux_issue) aux_state_d = A_WAIT;
            A_WAIT:  aux_state_d = A_ACK;
            A_ACK:   aux_state_d = A_IDLE;
            default: aux_state_d = A_IDLE;
        endcase
    end

    // Aux FSM outputs: a pending request is deferred (not dropped) on BG slots and HOLD.
    always_comb begin
        aux_issue   = (aux_state_q == A_IDLE) && AUX_REQ && !HOLD && !bg_slot_cycle;
        aux_capture = (aux_state_q == A_WAIT);
    end

    // Issue mux: at most one access per cycle; idle cycles keep the last address.
    always_comb begin
        rom_ad_d = rom_ad_q;
        tag_d    = TAG_NONE;
        if (slot_bg0) begin
            rom_ad_d = BG0_AD;
            tag_d    = TAG_BG0;
        end else if (slot_bg1) begin
            rom_ad_d = BG1_AD;
            tag_d    = TAG_BG1;
        end else if (aux_issue) begin
            rom_ad_d = AUX_AD;
            tag_d    = TAG_AUX;
        end
    end

    // Data capture by tag, and the character-boundary transfer of the BG holds.
    // The BG0 fetch issued on a boundary lands one edge later, so the transfer
    // always moves data fetched during the previous period.
    always_comb begin
        bg0_hold_d = bg0_hold_q;
        bg1_hold_d = bg1_hold_q;
        aux_dt_d   = aux_dt_q;
        aux_ack_d  = aux_capture;
        if (tag_q == TAG_BG0) bg0_hold_d = ROM_DT;
        if (tag_q == TAG_BG1) bg1_hold_d = ROM_DT;
        if (tag_q == TAG_AUX) aux_dt_d   = ROM_DT;
        bg0_dt_d = slot_bg0 ? bg0_hold_q : bg0_dt_q;
        bg1_dt_d = slot_bg0 ? bg1_hold_q : bg1_dt_q;
        bg_stb_d = slot_bg0;
    end

    // Datapath registers.
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            tag_q      <= TAG_NONE;
            rom_ad_q   <= '0;
            bg0_hold_q <= '0;
            bg1_hold_q <= '0;
            bg0_dt_q   <= '0;
            bg1_dt_q   <= '0;
            bg_stb_q   <= 1'b0;
            aux_dt_q   <= '0;
            aux_ack_q  <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            rom_ad_q   <= rom_ad_d;
            bg0_hold_q <= bg0_hold_d;
            bg1_hold_q <= bg1_hold_d;
            bg0_dt_q   <= bg0_dt_d;
            bg1_dt_q   <= bg1_dt_d;
            bg_stb_q   <= bg_stb_d;
            aux_dt_q   <= aux_dt_d;
            aux_ack_q  <= aux_ack_d;
        end
    end

    assign ROM_AD  = rom_ad_q;
    assign BG0_DT  = bg0_dt_q;
    assign BG1_DT  = bg1_dt_q;
    assign BG_STB  = bg_stb_q;
    assign AUX_DT  = aux_dt_q;
    assign AUX_ACK = aux_ack_q;

endmodule
